// File: rtl/rr_burst_scheduler_if.sv
// Handshake bundle between requester FIFOs, the burst scheduler and the shared downstream port.
// req_lock_i exists only when RR_SCHED_LOCK_EN is defined.
interface rr_burst_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]         req_valid_i;
    logic [NUM_REQ*DATA_W-1:0]  req_data_i;
    logic [NUM_REQ-1:0]         req_last_i;
    logic [NUM_REQ-1:0]         req_ready_o;
`ifdef RR_SCHED_LOCK_EN
    logic [NUM_REQ-1:0]         req_lock_i;
`endif
    logic                       out_valid_o;
    logic [DATA_W-1:0]          out_data_o;
    logic                       out_last_o;
    logic                       out_ready_i;
    logic [$clog2(NUM_REQ)-1:0] out_id_o;
    logic [NUM_REQ-1:0]         gnt_o;
    logic                       busy_o;

    // Scheduler side: consumes requests and downstream ready
    modport slave (
`ifdef RR_SCHED_LOCK_EN
        input  req_lock_i,
`endif
        input  req_valid_i, req_data_i, req_last_i, out_ready_i,
        output req_ready_o, out_valid_o, out_data_o, out_last_o,
        output out_id_o, gnt_o, busy_o
    );

    modport master (
`ifdef RR_SCHED_LOCK_EN
        output req_lock_i,
`endif
        output req_valid_i, req_data_i, req_last_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_data_o, out_last_o,
        input  out_id_o, gnt_o, busy_o
    );
endinterface

// File: rtl/rr_burst_scheduler.sv
// Burst-granular round-robin scheduler sharing one valid/ready port among NUM_REQ requesters.
// Optional feature macro: RR_SCHED_LOCK_EN (requester may hold its grant across bursts).
module rr_burst_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    rr_burst_scheduler_if.slave   bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_mask;
    logic [NUM_REQ-1:0] r_gnt;
    logic [ID_W-1:0]    r_id;
    logic [CNT_W-1:0]   r_beatCnt;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_maskedReq;
    logic [NUM_REQ-1:0] w_pickSrc;
    logic [ID_W-1:0]    w_pickId;
    logic [NUM_REQ-1:0] w_maskAbove;
    logic               w_selValid;
    logic               w_selLast;
    logic [DATA_W-1:0]  w_selData;
    logic               w_outValid;
    logic               w_outLast;
    logic               w_xfer;
    logic               w_lock;

    // Masked pick wins; an empty masked set falls back to plain lowest-index priority
    always_comb begin
        w_maskedReq = bus.req_valid_i & r_mask;
        w_pickSrc   = (|w_maskedReq) ? w_maskedReq : bus.req_valid_i;
        w_pickId    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_pickSrc[i]) w_pickId = ID_W'(i);
        end
        w_maskAbove = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_maskAbove[i] = (i > int'(r_id));
        end
    end

    assign w_selValid = bus.req_valid_i[r_id];
    assign w_selLast  = bus.req_last_i[r_id];
    assign w_selData  = bus.req_data_i[r_id*DATA_W +: DATA_W];
    assign w_outValid = r_busy & w_selValid;
    assign w_outLast  = w_outValid & (w_selLast | (r_beatCnt == CNT_W'(MAX_BEATS - 1)));
    assign w_xfer     = w_outValid & bus.out_ready_i;

`ifdef RR_SCHED_LOCK_EN
    assign w_lock = bus.req_lock_i[r_id];
`else
    assign w_lock = 1'b0;
`endif

    assign bus.out_valid_o = w_outValid;
    assign bus.out_data_o  = r_busy ? w_selData : '0;
    assign bus.out_last_o  = w_outLast;
    assign bus.req_ready_o = r_gnt & {NUM_REQ{bus.out_ready_i}};
    assign bus.out_id_o    = r_id;
    assign bus.gnt_o       = r_gnt;
    assign bus.busy_o      = r_busy;

    // Forced-last beats end the grant exactly like a requester last beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_mask    <= '1;
            r_gnt     <= '0;
            r_id      <= '0;
            r_beatCnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req_valid_i) begin
                        r_gnt     <= NUM_REQ'(1) << w_pickId;
                        r_id      <= w_pickId;
                        r_beatCnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_xfer) begin
                        if (w_outLast) begin
                            r_beatCnt <= '0;
                            if (!w_lock) begin
                                r_mask  <= w_maskAbove;
                                r_gnt   <= '0;
                                r_id    <= '0;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_beatCnt <= r_beatCnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Directed bench for rr_burst_scheduler: behavioural requesters feed bursts, a monitor logs grants and bursts.
// Lock scenario is compiled only with RR_SCHED_LOCK_EN.
module tb_rr_burst_scheduler;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    rr_burst_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    rr_burst_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int testsRun = 0;
    int testsFailed = 0;
    int cycle;

    int srcLen[NR], srcBursts[NR], srcSent[NR], srcSeq[NR], srcStallAt[NR], srcStallLeft[NR];
    logic [NR-1:0] stallNow, lastNow, prevGnt;
    int lockLeft;
    bit readyToggle, stallCheckEn;
    int stallSeen;

    int expSeq[NR];
    int monBeats, xferId;
    int grantId[32], grantCycle[32], grantCount;
    int burstId[32], burstBeats[32], burstCycle[32], burstCount;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive requester and downstream inputs from the behavioural source state
    task automatic applyStimulus();
        logic [NR-1:0]    v, l;
        logic [NR*DW-1:0] d;
        bit               active;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NR; i++) begin
            active      = srcBursts[i] > 0;
            stallNow[i] = active && (srcSent[i] == srcStallAt[i]) && (srcStallLeft[i] > 0);
            v[i]        = active && !stallNow[i];
            l[i]        = (srcSent[i] == srcLen[i] - 1);
            d[i*DW +: DW] = {8'(i), 24'(srcSeq[i])};
        end
        lastNow         = l;
        bus.req_valid_i = v;
        bus.req_last_i  = l;
        bus.req_data_i  = d;
        bus.out_ready_i = readyToggle ? ((cycle % 2) == 1) : 1'b1;
`ifdef RR_SCHED_LOCK_EN
        bus.req_lock_i  = (lockLeft > 0) ? 4'b0100 : 4'b0000;
`endif
    endtask

    task automatic monitorSample();
        int  id;
        bit  expLast;
        if (bus.gnt_o != '0 && prevGnt == '0 && grantCount < 32) begin
            grantId[grantCount]    = int'(bus.out_id_o);
            grantCycle[grantCount] = cycle;
            grantCount++;
        end
        prevGnt = bus.gnt_o;
        if (stallCheckEn && stallNow[1]) begin
            stallSeen++;
            checkOutput("stallValid", 64'(bus.out_valid_o), 64'(0));
            checkOutput("stallBusy", 64'(bus.busy_o), 64'(1));
            checkOutput("stallGnt", 64'(bus.gnt_o), 64'(4'b0010));
        end
        xferId = -1;
        if (bus.out_valid_o && bus.out_ready_i) begin
            id = int'(bus.out_id_o);
            xferId = id;
            monBeats++;
            checkOutput("gntOneHot", 64'(bus.gnt_o), 64'(1) << id);
            checkOutput("readyRoute", 64'(bus.req_ready_o), 64'(1) << id);
            checkOutput("beatData", 64'(bus.out_data_o), 64'((id << 24) | expSeq[id]));
            expLast = lastNow[id] || (monBeats == MB);
            checkOutput("beatLast", 64'(bus.out_last_o), 64'(expLast));
            expSeq[id]++;
            if (bus.out_last_o && burstCount < 32) begin
                burstId[burstCount]    = id;
                burstBeats[burstCount] = monBeats;
                burstCycle[burstCount] = cycle;
                burstCount++;
                monBeats = 0;
            end
        end
    endtask

    task automatic updateSources();
        for (int i = 0; i < NR; i++) begin
            if (stallNow[i]) srcStallLeft[i]--;
            if (xferId == i) begin
                srcSeq[i]++;
                srcSent[i]++;
                if (srcSent[i] == srcLen[i]) begin
                    srcSent[i] = 0;
                    srcBursts[i]--;
                    if (i == 2 && lockLeft > 0) lockLeft--;
                end
            end
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            monitorSample();
            @(posedge clk);
            #1;
            cycle++;
            updateSources();
            applyStimulus();
        end
    endtask

    // Reset DUT and bench models; outputs are checked while reset is held
    task automatic applyReset();
        reset_n = 1'b0;
        for (int i = 0; i < NR; i++) begin
            srcLen[i] = 1; srcBursts[i] = 0; srcSent[i] = 0; srcSeq[i] = 0;
            srcStallAt[i] = -1; srcStallLeft[i] = 0; expSeq[i] = 0;
        end
        readyToggle = 0; stallCheckEn = 0; lockLeft = 0; stallSeen = 0; cycle = 0;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstGnt", 64'(bus.gnt_o), 64'(0));
        checkOutput("rstBusy", 64'(bus.busy_o), 64'(0));
        checkOutput("rstValid", 64'(bus.out_valid_o), 64'(0));
        checkOutput("rstReady", 64'(bus.req_ready_o), 64'(0));
        checkOutput("rstLast", 64'(bus.out_last_o), 64'(0));
        checkOutput("rstId", 64'(bus.out_id_o), 64'(0));
        for (int i = 0; i < 32; i++) begin
            grantId[i] = -1; grantCycle[i] = -1;
            burstId[i] = -1; burstBeats[i] = -1; burstCycle[i] = -1;
        end
        grantCount = 0; burstCount = 0; monBeats = 0; prevGnt = '0; xferId = -1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // All four requesting single-beat bursts: strict rotation, one grant every 2 cycles
        applyReset();
        for (int i = 0; i < NR; i++) srcBursts[i] = 100;
        applyStimulus();
        runCycles(12);
        checkOutput("rotGrant0", 64'(grantId[0]), 64'(0));
        checkOutput("rotGrant1", 64'(grantId[1]), 64'(1));
        checkOutput("rotGrant2", 64'(grantId[2]), 64'(2));
        checkOutput("rotGrant3", 64'(grantId[3]), 64'(3));
        checkOutput("rotGrant4", 64'(grantId[4]), 64'(0));
        checkOutput("rotSpacing", 64'(grantCycle[4] - grantCycle[0]), 64'(8));

        // Requesters 1 and 3 with 3-beat bursts under a toggling downstream ready
        applyReset();
        srcLen[1] = 3; srcBursts[1] = 2;
        srcLen[3] = 3; srcBursts[3] = 1;
        readyToggle = 1;
        applyStimulus();
        runCycles(40);
        checkOutput("togCount", 64'(burstCount), 64'(3));
        checkOutput("togId0", 64'(burstId[0]), 64'(1));
        checkOutput("togId1", 64'(burstId[1]), 64'(3));
        checkOutput("togId2", 64'(burstId[2]), 64'(1));
        checkOutput("togBeats0", 64'(burstBeats[0]), 64'(3));
        checkOutput("togBeats1", 64'(burstBeats[1]), 64'(3));
        checkOutput("togBeats2", 64'(burstBeats[2]), 64'(3));

        // 40-beat packet from requester 0 split at MAX_BEATS, requester 2 slips in between
        applyReset();
        srcLen[0] = 40; srcBursts[0] = 1;
        srcLen[2] = 2;  srcBursts[2] = 1;
        applyStimulus();
        runCycles(60);
        checkOutput("longCount", 64'(burstCount), 64'(4));
        checkOutput("longId0", 64'(burstId[0]), 64'(0));
        checkOutput("longId1", 64'(burstId[1]), 64'(2));
        checkOutput("longId2", 64'(burstId[2]), 64'(0));
        checkOutput("longId3", 64'(burstId[3]), 64'(0));
        checkOutput("longBeats0", 64'(burstBeats[0]), 64'(16));
        checkOutput("longBeats1", 64'(burstBeats[1]), 64'(2));
        checkOutput("longBeats2", 64'(burstBeats[2]), 64'(16));
        checkOutput("longBeats3", 64'(burstBeats[3]), 64'(8));

        // Granted requester drops valid for 5 cycles after 3 beats
        applyReset();
        srcLen[1] = 10; srcBursts[1] = 1; srcStallAt[1] = 3; srcStallLeft[1] = 5;
        stallCheckEn = 1;
        applyStimulus();
        runCycles(30);
        checkOutput("stallCycles", 64'(stallSeen), 64'(5));
        checkOutput("stallBursts", 64'(burstCount), 64'(1));
        checkOutput("stallBeats", 64'(burstBeats[0]), 64'(10));

        // Asynchronous reset in the middle of a burst from requester 2
        applyReset();
        srcLen[2] = 10; srcBursts[2] = 1;
        applyStimulus();
        runCycles(4);
        checkOutput("midGntBefore", 64'(bus.gnt_o), 64'(4'b0100));
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midRstGnt", 64'(bus.gnt_o), 64'(0));
        checkOutput("midRstBusy", 64'(bus.busy_o), 64'(0));
        checkOutput("midRstValid", 64'(bus.out_valid_o), 64'(0));
        applyReset();
        for (int i = 1; i < NR; i++) srcBursts[i] = 5;
        applyStimulus();
        runCycles(4);
        checkOutput("postRstGrant", 64'(grantId[0]), 64'(1));

`ifdef RR_SCHED_LOCK_EN
        // Requester 2 locks its first burst: 2,2 back-to-back, then 3
        applyReset();
        for (int i = 0; i < NR; i++) srcBursts[i] = 100;
        lockLeft = 1;
        applyStimulus();
        runCycles(14);
        checkOutput("lockId2", 64'(burstId[2]), 64'(2));
        checkOutput("lockId3", 64'(burstId[3]), 64'(2));
        checkOutput("lockId4", 64'(burstId[4]), 64'(3));
        checkOutput("lockNoIdle", 64'(burstCycle[3] - burstCycle[2]), 64'(1));
        checkOutput("lockRelease", 64'(burstCycle[4] - burstCycle[3]), 64'(2));
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
